updown_counter: RTL and testbench

Parametrised up/down counter: the next generation of the team's 8-bit enable counter. It adds configurable width and modulus, direction control, synchronous load, and a choice of wrap or saturate at the limits. A registered wrap pulse is provided for cascading. It sits in the fabric clock domain behind the PLL and drives LED/status logic and timebase chains; an optional prescaler slows the count rate without extra logic in the parent.

---
 rtl/counter_pkg.sv | 16 +
 rtl/updown_counter_tick_prescaler.sv | 37 +++
 rtl/updown_counter.sv | 103 ++++++++++
 tb/tb_updown_counter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// counter_pkg: shared constants and helpers for updown_counter.
//   DIR_DOWN / DIR_UP   : encodings of the dir input
//   MODE_WRAP / MODE_SAT: encodings of the sat input
//   clamp_width(n)      : bits needed to count 0..n-1, never less than 1
package counter_pkg;

    localparam logic DIR_DOWN  = 1'b0;
    localparam logic DIR_UP    = 1'b1;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    function automatic int clamp_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/updown_counter_tick_prescaler.sv
// tick_prescaler: divides enabled cycles by DIV and emits tick on the last one.
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset
//   enable : count advances only while high; low freezes the count
//   clear  : synchronous clear, overrides enable
//   tick   : combinational, high while count == DIV-1
// With DIV=1 the count stays at 0, so tick is permanently high.
module tick_prescaler
    import counter_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int            CW   = clamp_width(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= tick ? '0 : count_reg + CW'(1);
        end
    end

    assign tick = (count_reg == LAST);

endmodule

// File: rtl/updown_counter.sv
// updown_counter: parametrised up/down counter with load, wrap/saturate
// select and a registered wrap pulse for cascading.
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   enable     : count enable
//   load       : synchronous load strobe (beats stepping)
//   load_value : value taken on load, clamped to MAX_COUNT
//   dir        : 1 = up, 0 = down
//   sat        : 1 = saturate at limits, 0 = wrap
//   out        : registered count
//   wrap       : registered one-cycle pulse after a wrapping step
//   at_limit   : combinational, out at the limit in the current direction
// Optional feature macro: UPDOWN_COUNTER_PRESCALE_EN inserts a tick_prescaler
// so a step happens only once every PRESCALE_DIV enabled cycles.
module updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int MAX_COUNT    = 2**WIDTH - 1,
    parameter int PRESCALE_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dir,
    input  logic             sat,
    output logic [WIDTH-1:0] out,
    output logic             wrap,
    output logic             at_limit
);

    localparam logic [WIDTH-1:0] LIMIT = WIDTH'(MAX_COUNT);

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;
    logic             wrap_reg;
    logic             wrap_next;
    logic             tick;
    logic             step;

`ifdef UPDOWN_COUNTER_PRESCALE_EN
    // load clears the prescaler so the step phase restarts from the loaded value
    tick_prescaler #(
        .DIV (PRESCALE_DIV)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .clear  (load),
        .tick   (tick)
    );
`else
    localparam int unused_prescale_div = PRESCALE_DIV;
    assign tick = 1'b1;
`endif

    assign step = enable && tick;

    always_comb begin
        count_next = count_reg;
        wrap_next  = 1'b0;
        if (load) begin
            count_next = (load_value > LIMIT) ? LIMIT : load_value;
        end else if (step) begin
            if (dir == DIR_UP) begin
                if (count_reg == LIMIT) begin
                    if (sat == MODE_WRAP) begin
                        count_next = '0;
                        wrap_next  = 1'b1;
                    end
                end else begin
                    count_next = count_reg + WIDTH'(1);
                end
            end else begin
                if (count_reg == '0) begin
                    if (sat == MODE_WRAP) begin
                        count_next = LIMIT;
                        wrap_next  = 1'b1;
                    end
                end else begin
                    count_next = count_reg - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
            wrap_reg  <= 1'b0;
        end else begin
            count_reg <= count_next;
            wrap_reg  <= wrap_next;
        end
    end

    assign out      = count_reg;
    assign wrap     = wrap_reg;
    assign at_limit = (dir == DIR_UP) ? (count_reg == LIMIT) : (count_reg == '0);

endmodule

// File: tb/tb_updown_counter.sv
// tb_updown_counter: three counter instances (8-bit full range, 4-bit modulo 10,
// 8-bit modulo 100) driven from one directed sequence; a reference model
// pushes expected values into a scoreboard queue before each edge and the
// entries are popped and compared one cycle later.
module tb_updown_counter;

`ifdef UPDOWN_COUNTER_PRESCALE_EN
    localparam int PD8 = 4;
`else
    localparam int PD8 = 1;
`endif
    localparam int MAXC [3] = '{255, 9, 99};
    localparam int PDV  [3] = '{PD8, 1, 1};

    typedef struct {
        int   inst;
        int   out;
        logic wrap;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en [3];
    logic       ld [3];
    logic       dr [3];
    logic       st [3];
    logic [7:0] lv [3];

    logic [7:0] o8, o99;
    logic [3:0] o9;
    logic       w8, w9, w99, al8, al9, al99;
    logic [7:0] dout [3];
    logic       dwrap [3];
    logic       dal [3];

    int   m_out [3];
    int   m_pc  [3];
    exp_t sb_q [$];
    int   checks = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    updown_counter #(.WIDTH(8), .MAX_COUNT(255), .PRESCALE_DIV(4)) u8 (
        .clk(clk), .rst(rst), .enable(en[0]), .load(ld[0]), .load_value(lv[0]),
        .dir(dr[0]), .sat(st[0]), .out(o8), .wrap(w8), .at_limit(al8));

    updown_counter #(.WIDTH(4), .MAX_COUNT(9), .PRESCALE_DIV(1)) u9 (
        .clk(clk), .rst(rst), .enable(en[1]), .load(ld[1]), .load_value(lv[1][3:0]),
        .dir(dr[1]), .sat(st[1]), .out(o9), .wrap(w9), .at_limit(al9));

    updown_counter #(.WIDTH(8), .MAX_COUNT(99), .PRESCALE_DIV(1)) u99 (
        .clk(clk), .rst(rst), .enable(en[2]), .load(ld[2]), .load_value(lv[2]),
        .dir(dr[2]), .sat(st[2]), .out(o99), .wrap(w99), .at_limit(al99));

    assign dout[0]  = o8;
    assign dout[1]  = {4'b0000, o9};
    assign dout[2]  = o99;
    assign dwrap[0] = w8;
    assign dwrap[1] = w9;
    assign dwrap[2] = w99;
    assign dal[0]   = al8;
    assign dal[1]   = al9;
    assign dal[2]   = al99;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    endtask

    // Reference model: predict every instance for the coming edge, push, clock, pop and compare.
    task automatic cycle();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            int   o;
            int   pc;
            logic w;
            o  = m_out[i];
            pc = m_pc[i];
            w  = 1'b0;
            if (ld[i]) begin
                o  = (int'(lv[i]) > MAXC[i]) ? MAXC[i] : int'(lv[i]);
                pc = 0;
            end else begin
                logic tk;
                tk = (pc == PDV[i] - 1);
                if (en[i]) pc = tk ? 0 : pc + 1;
                if (en[i] && tk) begin
                    if (dr[i]) begin
                        if (o == MAXC[i]) begin
                            if (!st[i]) begin o = 0; w = 1'b1; end
                        end else o = o + 1;
                    end else begin
                        if (o == 0) begin
                            if (!st[i]) begin o = MAXC[i]; w = 1'b1; end
                        end else o = o - 1;
                    end
                end
            end
            m_out[i] = o;
            m_pc[i]  = pc;
            e.inst = i;
            e.out  = o;
            e.wrap = w;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        while (sb_q.size() > 0) begin
            logic exp_al;
            e = sb_q.pop_front();
            exp_al = dr[e.inst] ? (e.out == MAXC[e.inst]) : (e.out == 0);
            chk($sformatf("inst%0d_out", e.inst), 32'(dout[e.inst]), 32'(e.out));
            chk($sformatf("inst%0d_wrap", e.inst), 32'(dwrap[e.inst]), 32'(e.wrap));
            chk($sformatf("inst%0d_at_limit", e.inst), 32'(dal[e.inst]), 32'(exp_al));
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_out[i] = 0;
            m_pc[i]  = 0;
        end
    endtask

    initial begin
        int wraps;
        int start;
        for (int i = 0; i < 3; i++) begin
            en[i] = 1'b0; ld[i] = 1'b0; dr[i] = 1'b0; st[i] = 1'b0; lv[i] = 8'd0;
        end
        model_reset();

        // Reset state
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("reset_out8", 32'(o8), 32'd0);
        chk("reset_wrap8", 32'(w8), 32'd0);
        chk("reset_at_limit_down", 32'(al8), 32'd1);
        rst = 1'b0;
        $display("reset released");

        // Full-range up count with wrap
        en[0] = 1'b1; dr[0] = 1'b1; st[0] = 1'b0;
        wraps = 0;
        for (int n = 0; n < 256 * PD8; n++) begin
            cycle();
            if (w8) begin
                wraps++;
                chk("wrap_at_zero", 32'(o8), 32'd0);
            end
        end
        chk("full_run_wrap_count", 32'(wraps), 32'd1);
        chk("full_run_end", 32'(o8), 32'd0);
        $display("full run: out=%0d wraps=%0d", o8, wraps);
        en[0] = 1'b0;

        // Modulo-10 down wrap from 0
        dr[1] = 1'b0; st[1] = 1'b0; en[1] = 1'b1;
        cycle();
        chk("mod10_down_wrap_out", 32'(o9), 32'd9);
        chk("mod10_down_wrap_pulse", 32'(w9), 32'd1);
        en[1] = 1'b0;
        cycle();
        chk("mod10_wrap_one_cycle", 32'(w9), 32'd0);
        $display("mod10 down wrap: out=%0d", o9);

        // Saturate up: load 3 then 15 steps
        ld[1] = 1'b1; lv[1] = 8'd3;
        cycle();
        ld[1] = 1'b0; dr[1] = 1'b1; st[1] = 1'b1; en[1] = 1'b1;
        wraps = 0;
        for (int n = 0; n < 15; n++) begin
            cycle();
            if (w9) wraps++;
        end
        chk("sat_hold", 32'(o9), 32'd9);
        chk("sat_no_wrap", 32'(wraps), 32'd0);
        chk("sat_at_limit", 32'(al9), 32'd1);
        $display("saturate: out=%0d at_limit=%0d", o9, al9);
        en[1] = 1'b0;

        // Load clamp with enable high, then pass-through and down wrap to 99
        ld[2] = 1'b1; lv[2] = 8'd200; en[2] = 1'b1; dr[2] = 1'b1;
        cycle();
        chk("load_clamp", 32'(o99), 32'd99);
        chk("load_no_wrap", 32'(w99), 32'd0);
        lv[2] = 8'd42;
        cycle();
        chk("load_in_range", 32'(o99), 32'd42);
        lv[2] = 8'd0;
        cycle();
        ld[2] = 1'b0; dr[2] = 1'b0; st[2] = 1'b0;
        cycle();
        chk("mod100_down_wrap", 32'(o99), 32'd99);
        chk("mod100_wrap_pulse", 32'(w99), 32'd1);
        en[2] = 1'b0;
        cycle();
        $display("mod100 load/wrap: out=%0d", o99);

        // Asynchronous reset between edges at out=37
        ld[0] = 1'b1; lv[0] = 8'd37;
        cycle();
        ld[0] = 1'b0;
        chk("pre_reset_37", 32'(o8), 32'd37);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_out", 32'(o8), 32'd0);
        chk("async_reset_wrap", 32'(w8), 32'd0);
        chk("async_reset_out99", 32'(o99), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        $display("async reset: out=%0d", o8);

        // Prescaled stepping with enable dropped midway
        dr[0] = 1'b1; st[0] = 1'b0;
        start = int'(o8);
        en[0] = 1'b1;
        for (int n = 0; n < 6; n++) cycle();
        en[0] = 1'b0;
        for (int n = 0; n < 3; n++) cycle();
        en[0] = 1'b1;
        for (int n = 0; n < 6; n++) cycle();
        en[0] = 1'b0;
        chk("prescale_advance", 32'(int'(o8) - start), 32'(12 / PD8));
        $display("prescale: advanced by %0d", int'(o8) - start);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
